// File: rtl/code_rom_arbiter.sv
// Two-port arbiter for the byte-wide program ROM: multi-byte instruction fetch bursts (IF)
// and single-byte MOVC reads (MV), round-robin on ties, with registered ROM-side outputs.
module code_rom_arbiter #(
  parameter int unsigned ADDRWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [ADDRWIDTH-1:0] if_addr,
  input  logic [1:0]           if_len,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [7:0]           if_rdata,
  output logic                 if_last,
  input  logic                 mv_req,
  input  logic [ADDRWIDTH-1:0] mv_addr,
  output logic                 mv_gnt,
  output logic                 mv_rvalid,
  output logic [7:0]           mv_rdata,
  output logic                 rom_cs_n,
  output logic [ADDRWIDTH-1:0] rom_addr,
  input  logic [7:0]           rom_dout,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StIfBurst, StMvRead} state_e;

  state_e               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic                 if_gnt_q, if_gnt_d;
  logic                 mv_gnt_q, mv_gnt_d;
  logic                 prio_mv_q, prio_mv_d;
  logic                 cs_n_q, busy_q;
  logic                 if_rvalid_q, if_last_q, mv_rvalid_q;
  logic [7:0]           if_rdata_q, mv_rdata_q;
  logic                 arb, if_eff, mv_eff;

  // A request still held high in its own grant cycle is stale and must not win again.
  assign if_eff = if_req & ~if_gnt_q;
  assign mv_eff = mv_req & ~mv_gnt_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    if_gnt_d  = 1'b0;
    mv_gnt_d  = 1'b0;
    prio_mv_d = prio_mv_q;
    arb       = 1'b0;

    unique case (state_q)
      StIdle:   arb = 1'b1;
      StIfBurst: begin
        if (cnt_q == 2'd1) begin
          arb = 1'b1;
        end else begin
          cnt_d  = cnt_q - 2'd1;
          addr_d = addr_q + 1'b1;
        end
      end
      StMvRead: arb = 1'b1;
      default:  arb = 1'b1;
    endcase

    // Arbitrating in the final issue cycle lets the next transaction start without a bubble.
    if (arb) begin
      state_d = StIdle;
      if (if_eff && (!mv_eff || !prio_mv_q)) begin
        state_d   = StIfBurst;
        cnt_d     = (if_len == 2'd0) ? 2'd1 : if_len;
        addr_d    = if_addr;
        if_gnt_d  = 1'b1;
        prio_mv_d = 1'b1;
      end else if (mv_eff) begin
        state_d   = StMvRead;
        cnt_d     = 2'd1;
        addr_d    = mv_addr;
        mv_gnt_d  = 1'b1;
        prio_mv_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      addr_q      <= '0;
      if_gnt_q    <= 1'b0;
      mv_gnt_q    <= 1'b0;
      prio_mv_q   <= 1'b0;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_last_q   <= 1'b0;
      mv_rvalid_q <= 1'b0;
      if_rdata_q  <= 8'h00;
      mv_rdata_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      if_gnt_q    <= if_gnt_d;
      mv_gnt_q    <= mv_gnt_d;
      prio_mv_q   <= prio_mv_d;
      cs_n_q      <= (state_d == StIdle);
      busy_q      <= (state_d != StIdle);
      // Every non-idle cycle is an issue cycle, so its data arrives at this edge.
      if_rvalid_q <= (state_q == StIfBurst);
      if_last_q   <= (state_q == StIfBurst) && (cnt_q == 2'd1);
      mv_rvalid_q <= (state_q == StMvRead);
      if (state_q == StIfBurst) begin
        if_rdata_q <= rom_dout;
      end
      if (state_q == StMvRead) begin
        mv_rdata_q <= rom_dout;
      end
    end
  end

  assign if_gnt    = if_gnt_q;
  assign mv_gnt    = mv_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign if_last   = if_last_q;
  assign mv_rvalid = mv_rvalid_q;
  assign mv_rdata  = mv_rdata_q;
  assign rom_cs_n  = cs_n_q;
  assign rom_addr  = addr_q;
  assign busy      = busy_q;

endmodule
